// File: rtl/arith_pkg.sv
// Shared types and helpers for the ratio/gain magnitude datapath.
package arith_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIN,
        OUT
    } state_t;

    localparam int OVF_ZERO  = 0;
    localparam int OVF_CLAMP = 1;

    // Magnitude of a sign-extended value; the most negative input maps to 2^(w-1).
    function automatic logic [63:0] abs_mag(input logic signed [63:0] v);
        return v[63] ? unsigned'(-v) : unsigned'(v);
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// done_o is high during the final iteration, so quo_o is complete after that edge.
module seq_udiv #(
    parameter int NUM_W = 48,
    parameter int DEN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic             done_o,
    output logic [NUM_W-1:0] quo_o
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W:0]   trial;
    logic             ge;

    // Load on start, otherwise shift-subtract while the down-counter runs.
    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        den_d = den_q;
        quo_d = quo_q;
        trial = {rem_q, quo_q[NUM_W-1]};
        ge    = (trial >= {1'b0, den_q});
        if (start_i) begin
            cnt_d = CNT_W'(NUM_W);
            rem_d = '0;
            den_d = den_i;
            quo_d = num_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            rem_d = ge ? DEN_W'(trial - {1'b0, den_q}) : trial[DEN_W-1:0];
            quo_d = {quo_q[NUM_W-2:0], ge};
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            quo_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            den_q <= den_d;
            quo_q <= quo_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));
    assign quo_o  = quo_q;

endmodule

// File: rtl/arith_ratio_gain.sv
// Multichannel |i * Ku[ch] / q| with per-channel gain registers and
// saturate-or-zero on overflow / divide-by-zero. One sample in flight.
//
// state | meaning
// IDLE  | ready for a new sample
// MULT  | form |i| * Ku and start the divider
// DIV   | divider iterating, NUM_W cycles
// FIN   | scale, overflow check, register result
// OUT   | result presented, waiting for out_ready
module arith_ratio_gain
    import arith_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 8,
    parameter int OUT_W     = 32,
    parameter int N_CH      = 4,
    parameter int OVF_MODE  = OVF_ZERO,
    parameter logic [GAIN_W-1:0] GAIN_RST = GAIN_W'(1 << GAIN_FRAC),
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gain_we,
    input  logic [CH_W-1:0]   gain_addr,
    input  logic [GAIN_W-1:0] gain_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_i,
    input  logic [DATA_W-1:0] in_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_ovf,
    output logic              busy
);

    localparam int NUM_W = DATA_W + GAIN_W;
    localparam int MAXW  = (OUT_W > NUM_W) ? OUT_W : NUM_W;
    localparam logic [MAXW-1:0] OUT_MAX = {{(MAXW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

    state_t state_q, state_d;

    logic [GAIN_W-1:0] gain_q [N_CH];
    logic [GAIN_W-1:0] gain_rd;
    logic [DATA_W-1:0] mag_i, mag_q;
    logic [DATA_W-1:0] mag_i_q, mag_q_q;
    logic [GAIN_W-1:0] gain_lat_q;
    logic [CH_W-1:0]   ch_q;
    logic              div0_q;
    logic              accept;
    logic              div_start, div_done;
    logic [NUM_W-1:0]  prod, quo;
    logic [MAXW-1:0]   r_ext;
    logic              ovf;
    logic [OUT_W-1:0]  res;
    logic              out_valid_q, out_ovf_q;
    logic [OUT_W-1:0]  out_data_q;
    logic [CH_W-1:0]   out_ch_q;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;
    assign mag_i     = DATA_W'(abs_mag(64'(signed'(in_i))));
    assign mag_q     = DATA_W'(abs_mag(64'(signed'(in_q))));
    assign div_start = (state_q == MULT);
    assign prod      = NUM_W'(mag_i_q) * NUM_W'(gain_lat_q);

    // Gain lookup for the incoming channel; out-of-range channels see unity.
    always_comb begin
        gain_rd = GAIN_RST;
        if (int'(in_ch) < N_CH) gain_rd = gain_q[in_ch];
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = MULT;
            MULT:    state_d = DIV;
            DIV:     if (div_done) state_d = FIN;
            FIN:     state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Drop the Ku fraction, then saturate or zero on overflow / div0.
    always_comb begin
        r_ext = MAXW'(quo >> GAIN_FRAC);
        ovf   = div0_q || (r_ext > OUT_MAX);
        res   = OUT_W'(r_ext);
        if (ovf) res = (OVF_MODE == OVF_CLAMP) ? OUT_W'(OUT_MAX) : '0;
    end

    // Gain registers; a write on the accept edge lands after the old value is latched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) gain_q[c] <= GAIN_RST;
        end else if (gain_we && (int'(gain_addr) < N_CH)) begin
            gain_q[gain_addr] <= gain_data;
        end
    end

    // Operand capture at accept, result capture in FIN, release on output handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag_i_q     <= '0;
            mag_q_q     <= '0;
            gain_lat_q  <= '0;
            ch_q        <= '0;
            div0_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            if (accept) begin
                mag_i_q    <= mag_i;
                mag_q_q    <= mag_q;
                gain_lat_q <= gain_rd;
                ch_q       <= in_ch;
                div0_q     <= (in_q == '0);
            end
            if (state_q == FIN) begin
                out_valid_q <= 1'b1;
                out_ovf_q   <= ovf;
                out_data_q  <= res;
                out_ch_q    <= ch_q;
            end else if ((state_q == OUT) && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    seq_udiv #(
        .NUM_W(NUM_W),
        .DEN_W(DATA_W)
    ) u_div (
        .clk    (clk),
        .rst    (reset),
        .start_i(div_start),
        .num_i  (prod),
        .den_i  (mag_q_q),
        .done_o (div_done),
        .quo_o  (quo)
    );

    assign out_valid = out_valid_q;
    assign out_ovf   = out_ovf_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
